not16_response_checker: RTL and testbench

- Self-checking response end for the 16-bit gate test path. A stimulus source drives an incrementing operand X. The NOT16 under test returns OUT. This block consumes each (X, OUT) pair and checks both the result and the stimulus sequence.
- Checks per pair: OUT must equal bitwise NOT of X; X must follow the expected incrementing order.
- Accumulates error count, first-failure capture and an overall pass flag.
- Synthesizable; sits beside the gate datapath for on-chip built-in self-test (BIST).

---
 rtl/not16_chk_pkg.sv | 15 +
 rtl/chk_misr.sv | 45 ++++
 rtl/not16_response_checker.sv | 173 +++++++++++++++++
 tb/tb_not16_response_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/not16_chk_pkg.sv
// rtl/not16_chk_pkg.sv - shared types and constants for the NOT16 response checker
// Purpose: FSM state encoding and the MISR feedback polynomial.
// Ports: none (package).
package not16_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] MISR_POLY = 16'h1021;

endpackage

// File: rtl/chk_misr.sv
// rtl/chk_misr.sv - multiple-input signature register over the DUT results
// Purpose: folds each accepted result word into a running signature.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear (run start)
//   en    - fold din into the signature this cycle
//   din   - result word to fold
//   sig   - current signature
module chk_misr
    import not16_chk_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    // Narrow widths take the low bits of the 16-bit polynomial.
    localparam logic [WIDTH-1:0] POLY = WIDTH'(MISR_POLY);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (clr) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/not16_response_checker.sv
// rtl/not16_response_checker.sv - BIST response checker for the NOT16 gate path
// Purpose: consumes (X, OUT) pairs, checks OUT == ~X and that X increments from 0,
//   counts vectors and mismatches, captures the first mismatch and reports pass.
// Build option: NOT16_CHK_MISR_EN builds the result MISR; otherwise signature_o is 0.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - one-cycle pulse, begins a run from IDLE or DONE
//   vld_i, x_i, out_i - pair valid, stimulus operand, DUT result
//   rdy_o, busy_o     - high while a run is in progress
//   done_o, pass_o    - run complete / run complete with no errors
//   vec_cnt_o         - pairs accepted this run
//   err_cnt_o         - result mismatches (saturating)
//   seq_err_o         - sticky stimulus-sequence error
//   first_fail_x_o    - operand of the first mismatch
//   first_fail_out_o  - result of the first mismatch
//   signature_o       - MISR signature of accepted results
module not16_response_checker
    import not16_chk_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NUM_VECTORS = 100,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] out_i,
    output logic             rdy_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] vec_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             seq_err_o,
    output logic [WIDTH-1:0] first_fail_x_o,
    output logic [WIDTH-1:0] first_fail_out_o,
    output logic [WIDTH-1:0] signature_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS - 1);

    chk_state_e       state_q;
    logic             rdy_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] vec_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             seq_err_q;
    logic [WIDTH-1:0] ff_x_q;
    logic [WIDTH-1:0] ff_out_q;
    logic [WIDTH-1:0] exp_x_q;

    logic             start_run;
    logic             accept;
    logic             last_accept;
    logic             res_err;
    logic             seq_bad;
    logic [CNT_W-1:0] err_cnt_d;
    logic             seq_err_d;

    // rdy_q is high exactly in RUN, so it doubles as the accept qualifier.
    assign start_run   = start && (state_q != RUN);
    assign accept      = vld_i && rdy_q;
    assign last_accept = accept && (vec_cnt_q == LAST_CNT);
    assign res_err     = (out_i != ~x_i);
    assign seq_bad     = (x_i != exp_x_q);

    always_comb begin
        err_cnt_d = err_cnt_q;
        seq_err_d = seq_err_q;
        if (accept) begin
            if (res_err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (seq_bad) begin
                seq_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            seq_err_q <= 1'b0;
            ff_x_q    <= '0;
            ff_out_q  <= '0;
            exp_x_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_run) begin
                        state_q   <= RUN;
                        rdy_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        vec_cnt_q <= '0;
                        err_cnt_q <= '0;
                        seq_err_q <= 1'b0;
                        ff_x_q    <= '0;
                        ff_out_q  <= '0;
                        exp_x_q   <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        vec_cnt_q <= vec_cnt_q + 1'b1;
                        err_cnt_q <= err_cnt_d;
                        seq_err_q <= seq_err_d;
                        // err_cnt saturates and never returns to zero within a run,
                        // so zero means no mismatch has been captured yet.
                        if (res_err && (err_cnt_q == '0)) begin
                            ff_x_q   <= x_i;
                            ff_out_q <= out_i;
                        end
                        // In sequence x_i equals exp_x_q; out of sequence we resync
                        // to x_i. Either way the next expected operand is x_i + 1.
                        exp_x_q <= x_i + 1'b1;
                        if (last_accept) begin
                            state_q <= DONE;
                            rdy_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == '0) && !seq_err_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef NOT16_CHK_MISR_EN
    chk_misr #(
        .WIDTH (WIDTH)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_run),
        .en    (accept),
        .din   (out_i),
        .sig   (signature_o)
    );
`else
    assign signature_o = '0;
`endif

    assign rdy_o            = rdy_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign vec_cnt_o        = vec_cnt_q;
    assign err_cnt_o        = err_cnt_q;
    assign seq_err_o        = seq_err_q;
    assign first_fail_x_o   = ff_x_q;
    assign first_fail_out_o = ff_out_q;

endmodule

// File: tb/tb_not16_response_checker.sv
// tb/tb_not16_response_checker.sv - scoreboard bench for the NOT16 response checker
module tb_not16_response_checker;

    typedef struct {
        int unsigned vec;
        int unsigned err;
        int unsigned seq;
        int unsigned ffx;
        int unsigned ffo;
        int unsigned pass;
        int unsigned sig;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit, 100-vector instance
    logic        start = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] x16 = '0;
    logic [15:0] o16 = '0;
    logic        rdy, busy, done, pass, seq_err;
    logic [15:0] vec_cnt, err_cnt, ffx, ffo, sig;

    // 4-bit, 20-vector instance exercising operand wrap
    logic        start4 = 1'b0;
    logic        vld4 = 1'b0;
    logic [3:0]  x4 = '0;
    logic [3:0]  o4 = '0;
    logic        rdy4, busy4, done4, pass4, seq_err4;
    logic [7:0]  vec_cnt4, err_cnt4;
    logic [3:0]  ffx4, ffo4, sig4;

    not16_response_checker #(.WIDTH(16), .NUM_VECTORS(100), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vld_i(vld), .x_i(x16), .out_i(o16),
        .rdy_o(rdy), .busy_o(busy), .done_o(done), .pass_o(pass),
        .vec_cnt_o(vec_cnt), .err_cnt_o(err_cnt), .seq_err_o(seq_err),
        .first_fail_x_o(ffx), .first_fail_out_o(ffo), .signature_o(sig)
    );

    not16_response_checker #(.WIDTH(4), .NUM_VECTORS(20), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .vld_i(vld4), .x_i(x4), .out_i(o4),
        .rdy_o(rdy4), .busy_o(busy4), .done_o(done4), .pass_o(pass4),
        .vec_cnt_o(vec_cnt4), .err_cnt_o(err_cnt4), .seq_err_o(seq_err4),
        .first_fail_x_o(ffx4), .first_fail_out_o(ffo4), .signature_o(sig4)
    );

    int checks = 0;
    int errors = 0;
    exp_t q16[$];
    exp_t q4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d,
                                              input int w);
        logic [15:0] mask;
        logic [15:0] r;
        mask = 16'((32'd1 << w) - 1);
        r = (s << 1) ^ (s[w-1] ? 16'h1021 : 16'h0000) ^ d;
        return r & mask;
    endfunction

    // mode 0 clean, 1 bad result at X=5, 2 skipped X=10
    function automatic logic [15:0] gen_x(input int mode, input int i);
        return (mode == 2 && i >= 10) ? 16'(i + 1) : 16'(i);
    endfunction

    function automatic logic [15:0] gen_o(input int mode, input int i);
        logic [15:0] xv;
        xv = gen_x(mode, i);
        return (mode == 1 && xv == 16'd5) ? 16'h0000 : ~xv;
    endfunction

    task automatic send16(input logic [15:0] xv, input logic [15:0] ov);
        vld = 1'b1; x16 = xv; o16 = ov;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q16.size() != 0 || q4.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, 32'(q16.size() + q4.size()), 32'd0);
    endtask

    task automatic run16(input int mode, input bit gaps, input string name);
        exp_t e;
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 100; i++) s = misr_step(s, gen_o(mode, i), 16);
        e.vec  = 100;
        e.err  = (mode == 1) ? 1 : 0;
        e.seq  = (mode == 2) ? 1 : 0;
        e.ffx  = (mode == 1) ? 5 : 0;
        e.ffo  = 0;
        e.pass = (mode == 0) ? 1 : 0;
`ifdef NOT16_CHK_MISR_EN
        e.sig  = 32'(s);
`else
        e.sig  = 0;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy"}, 32'(busy), 32'd1);
        chk({name, "_vec0"}, 32'(vec_cnt), 32'd0);
        q16.push_back(e);
        for (int i = 0; i < 100; i++) begin
            if (i == 99) chk({name, "_done_before_last"}, 32'(done), 32'd0);
            send16(gen_x(mode, i), gen_o(mode, i));
            if (i == 99) begin
                chk({name, "_done_after_last"}, 32'(done), 32'd1);
                chk({name, "_rdy_after_last"}, 32'(rdy), 32'd0);
            end
            if (mode == 2 && i == 10) chk({name, "_seq_after_skip"}, 32'(seq_err), 32'd1);
            if (gaps) @(negedge clk);
        end
        wait_drain(name);
        for (int i = 0; i < 3; i++) send16(16'(100 + i), ~16'(100 + i));
        chk({name, "_done_ignored"}, 32'(vec_cnt), 32'd100);
    endtask

    // Scoreboard monitors: pop and compare on each rising done.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (q16.size() == 0) begin
                    chk("m16_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q16.pop_front();
                    chk("m16_vec_cnt", 32'(vec_cnt), e.vec);
                    chk("m16_err_cnt", 32'(err_cnt), e.err);
                    chk("m16_seq_err", 32'(seq_err), e.seq);
                    chk("m16_ff_x", 32'(ffx), e.ffx);
                    chk("m16_ff_out", 32'(ffo), e.ffo);
                    chk("m16_pass", 32'(pass), e.pass);
                    chk("m16_busy", 32'(busy), 32'd0);
                    chk("m16_sig", 32'(sig), e.sig);
                end
            end
            prev = done;
        end
    end

    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done4 && !prev) begin
                if (q4.size() == 0) begin
                    chk("m4_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q4.pop_front();
                    chk("m4_vec_cnt", 32'(vec_cnt4), e.vec);
                    chk("m4_err_cnt", 32'(err_cnt4), e.err);
                    chk("m4_seq_err", 32'(seq_err4), e.seq);
                    chk("m4_pass", 32'(pass4), e.pass);
                    chk("m4_sig", 32'(sig4), e.sig);
                end
            end
            prev = done4;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [15:0] s;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_vec", 32'(vec_cnt), 32'd0);
        chk("reset_pass", 32'(pass), 32'd0);
        chk("reset_sig", 32'(sig), 32'd0);

        // pairs in IDLE are not accepted
        for (int i = 0; i < 3; i++) send16(16'(i), ~16'(i));
        chk("idle_ignored", 32'(vec_cnt), 32'd0);

        run16(0, 1'b0, "clean");
        run16(1, 1'b0, "bad_result");
        run16(2, 1'b0, "skip");
        run16(0, 1'b1, "gaps");

        // reset mid-run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50; i++) send16(16'(i), (i == 7) ? 16'h1234 : ~16'(i));
        chk("mid_vec50", 32'(vec_cnt), 32'd50);
        rst_n = 1'b0;
        #1;
        chk("arst_vec", 32'(vec_cnt), 32'd0);
        chk("arst_err", 32'(err_cnt), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rdy", 32'(rdy), 32'd0);
        chk("arst_ffx", 32'(ffx), 32'd0);
        chk("arst_ffo", 32'(ffo), 32'd0);
        chk("arst_sig", 32'(sig), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run16(0, 1'b0, "after_reset");

        // 4-bit instance: X wraps 15 -> 0 without a sequence error
        s = '0;
        for (int i = 0; i < 20; i++) s = misr_step(s, 16'(~4'(i % 16)), 4);
        e.vec = 20; e.err = 0; e.seq = 0; e.ffx = 0; e.ffo = 0; e.pass = 1;
`ifdef NOT16_CHK_MISR_EN
        e.sig = 32'(s);
`else
        e.sig = 0;
`endif
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        q4.push_back(e);
        for (int i = 0; i < 20; i++) begin
            vld4 = 1'b1; x4 = 4'(i % 16); o4 = ~4'(i % 16);
            @(negedge clk);
            vld4 = 1'b0;
            if (i == 16) chk("wrap_no_seq_err", 32'(seq_err4), 32'd0);
        end
        wait_drain("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
